// File: rtl/mdu_pkg.sv
// Shared definitions for the multiply/divide unit: op encodings, FSM states, latencies.
// Pure declarations; no logic, no latency, no backpressure.
package mdu_pkg;

    typedef enum logic [2:0] {
        MD_MULT  = 3'd0,
        MD_MULTU = 3'd1,
        MD_DIV   = 3'd2,
        MD_DIVU  = 3'd3,
        MD_MADD  = 3'd4,
        MD_MADDU = 3'd5,
        MD_MSUB  = 3'd6,
        MD_MSUBU = 3'd7
    } md_op_e;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } mdu_state_e;

    localparam int unsigned MULT_LAT = 5;
    localparam int unsigned DIV_LAT  = 10;

    localparam logic [3:0] MULT_CNT = 4'(MULT_LAT - 1);
    localparam logic [3:0] DIV_CNT  = 4'(DIV_LAT - 1);

    // Latched request: operation plus both operands, held for the whole BUSY period.
    typedef struct packed {
        md_op_e      op;
        logic [31:0] rs;
        logic [31:0] rt;
    } mdu_req_t;

    function automatic logic is_div_op(input logic [2:0] op);
        return (op == MD_DIV) || (op == MD_DIVU);
    endfunction

    function automatic logic [3:0] load_cnt(input logic [2:0] op);
        return is_div_op(op) ? DIV_CNT : MULT_CNT;
    endfunction

endpackage

// File: rtl/mdu_alu.sv
// Combinational MDU datapath: product, accumulate/subtract into {hi,lo}, divide with remainder.
// Zero latency; no backpressure (result is consumed on the commit edge by mdu_ctrl).
module mdu_alu
    import mdu_pkg::*;
(
    input  logic [2:0]  op,
    input  logic [31:0] rs,
    input  logic [31:0] rt,
    input  logic [63:0] hilo,
    output logic [63:0] result
);

    logic        is_signed;
    logic [63:0] rs_ext;
    logic [63:0] rt_ext;
    logic [63:0] prod;
    logic [31:0] dvd_mag;
    logic [31:0] dvs_mag;
    logic [31:0] quo_mag;
    logic [31:0] rem_mag;
    logic        quo_neg;
    logic        rem_neg;
    logic [31:0] quo;
    logic [31:0] rem;
    logic        div_zero;

    // Even encodings are the signed variants for every op class.
    assign is_signed = ~op[0];

    // Extending to 64 bits first makes the low 64 product bits correct for both signednesses.
    always_comb begin
        rs_ext = {{32{is_signed & rs[31]}}, rs};
        rt_ext = {{32{is_signed & rt[31]}}, rt};
        prod   = rs_ext * rt_ext;
    end

    // Signed divide is done on magnitudes, then the signs are restored (truncation toward zero).
    always_comb begin
        dvd_mag  = (is_signed && rs[31]) ? (32'd0 - rs) : rs;
        dvs_mag  = (is_signed && rt[31]) ? (32'd0 - rt) : rt;
        div_zero = (rt == 32'd0);
        quo_mag  = div_zero ? 32'd0 : (dvd_mag / dvs_mag);
        rem_mag  = div_zero ? 32'd0 : (dvd_mag % dvs_mag);
        quo_neg  = is_signed & (rs[31] ^ rt[31]);
        rem_neg  = is_signed & rs[31];
        quo      = quo_neg ? (32'd0 - quo_mag) : quo_mag;
        rem      = rem_neg ? (32'd0 - rem_mag) : rem_mag;
    end

    always_comb begin
        result = 64'd0;
        case (op)
            MD_MULT, MD_MULTU: result = prod;
            MD_MADD, MD_MADDU: result = hilo + prod;
            MD_MSUB, MD_MSUBU: result = hilo - prod;
            MD_DIV, MD_DIVU:   result = div_zero ? {rs, 32'hFFFF_FFFF} : {rem, quo};
            default:           result = 64'd0;
        endcase
    end

endmodule

// File: rtl/mdu_ctrl.sv
// Multiply/divide control: IDLE/BUSY FSM, latency counter, architectural HI/LO registers.
// Latency 5 (mult class) or 10 (div class) busy cycles; D stage is stalled via stall, requests while busy are dropped.
module mdu_ctrl
    import mdu_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [2:0]  op,
    input  logic        mt_hi,
    input  logic        mt_lo,
    input  logic [31:0] rs_val,
    input  logic [31:0] rt_val,
    input  logic        d_mdft,
    output logic        busy,
    output logic        stall,
    output logic [31:0] hi,
    output logic [31:0] lo
);

    mdu_state_e  state_q;
    mdu_state_e  state_d;
    logic [3:0]  cnt_q;
    logic [3:0]  cnt_d;
    mdu_req_t    req_q;
    mdu_req_t    req_d;
    logic [31:0] hi_q;
    logic [31:0] hi_d;
    logic [31:0] lo_q;
    logic [31:0] lo_d;
    logic [63:0] alu_res;

    mdu_alu u_alu (
        .op     (req_q.op),
        .rs     (req_q.rs),
        .rt     (req_q.rt),
        .hilo   ({hi_q, lo_q}),
        .result (alu_res)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= 4'd0;
            req_q   <= '0;
            hi_q    <= 32'd0;
            lo_q    <= 32'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            req_q   <= req_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        req_d   = req_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d  = BUSY;
                    cnt_d    = load_cnt(op);
                    req_d.op = md_op_e'(op);
                    req_d.rs = rs_val;
                    req_d.rt = rt_val;
                end else begin
                    if (mt_hi) hi_d = rs_val;
                    if (mt_lo) lo_d = rs_val;
                end
            end
            BUSY: begin
                // Any start/mt seen here is a protocol violation and is deliberately ignored.
                if (cnt_q == 4'd0) begin
                    state_d      = IDLE;
                    {hi_d, lo_d} = alu_res;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        busy  = (state_q == BUSY);
        stall = d_mdft & (start | busy);
        hi    = hi_q;
        lo    = lo_q;
    end

endmodule

// File: tb/tb_mdu_ctrl.sv
// Directed bench for mdu_ctrl: vector table for arithmetic and latency, hand sequences for
// stall, reset, and request-while-busy corner cases.
module tb_mdu_ctrl;
    import mdu_pkg::*;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [2:0]  op;
    logic        mt_hi;
    logic        mt_lo;
    logic [31:0] rs_val;
    logic [31:0] rt_val;
    logic        d_mdft;
    logic        busy;
    logic        stall;
    logic [31:0] hi;
    logic [31:0] lo;

    int n_total = 0;
    int n_pass  = 0;

    always #5 clk = ~clk;

    mdu_ctrl dut (
        .clk    (clk),
        .reset  (reset),
        .start  (start),
        .op     (op),
        .mt_hi  (mt_hi),
        .mt_lo  (mt_lo),
        .rs_val (rs_val),
        .rt_val (rt_val),
        .d_mdft (d_mdft),
        .busy   (busy),
        .stall  (stall),
        .hi     (hi),
        .lo     (lo)
    );

    typedef struct {
        logic [2:0]  op;
        logic [31:0] rs;
        logic [31:0] rt;
        logic        pre;
        logic [31:0] pre_hi;
        logic [31:0] pre_lo;
        int          lat;
        logic [31:0] ex_hi;
        logic [31:0] ex_lo;
    } vec_t;

    localparam int NVEC = 16;
    vec_t vecs [NVEC];

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h, expected %h", name, act, exp);
    endtask

    task automatic mt_write(input logic to_hi, input logic [31:0] v);
        mt_hi  = to_hi;
        mt_lo  = ~to_hi;
        rs_val = v;
        tick;
        mt_hi  = 1'b0;
        mt_lo  = 1'b0;
    endtask

    // Returns the number of cycles busy was observed high after the start edge.
    task automatic run_op(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                          output int nbusy);
        op     = o;
        rs_val = a;
        rt_val = b;
        start  = 1'b1;
        tick;
        start  = 1'b0;
        nbusy  = 0;
        while (busy === 1'b1 && nbusy < 40) begin
            nbusy++;
            tick;
        end
    endtask

    initial begin
        int nb;
        int stall_cnt;

        vecs[0]  = '{3'd0, 32'hFFFF_FFFD, 32'd7,        1'b0, 32'd0, 32'd0,        5,  32'hFFFF_FFFF, 32'hFFFF_FFEB};
        vecs[1]  = '{3'd3, 32'd100,       32'd7,        1'b0, 32'd0, 32'd0,        10, 32'd2,         32'd14};
        vecs[2]  = '{3'd2, 32'hFFFF_FFF9, 32'd2,        1'b0, 32'd0, 32'd0,        10, 32'hFFFF_FFFF, 32'hFFFF_FFFD};
        vecs[3]  = '{3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 32'd0, 32'd0,       5,  32'hFFFF_FFFE, 32'h0000_0001};
        vecs[4]  = '{3'd3, 32'd9,         32'd0,        1'b0, 32'd0, 32'd0,        10, 32'd9,         32'hFFFF_FFFF};
        vecs[5]  = '{3'd2, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, 32'd0, 32'd0,       10, 32'd0,         32'h8000_0000};
        vecs[6]  = '{3'd2, 32'd7,         32'hFFFF_FFFE, 1'b0, 32'd0, 32'd0,       10, 32'd1,         32'hFFFF_FFFD};
        vecs[7]  = '{3'd4, 32'd2,         32'd3,        1'b1, 32'd5, 32'd10,       5,  32'd5,         32'd16};
        vecs[8]  = '{3'd7, 32'd16,        32'd1,        1'b0, 32'd0, 32'd0,        5,  32'd5,         32'd0};
        vecs[9]  = '{3'd2, 32'hFFFF_FFF9, 32'd0,        1'b0, 32'd0, 32'd0,        10, 32'hFFFF_FFF9, 32'hFFFF_FFFF};
        vecs[10] = '{3'd5, 32'd1,         32'd1,        1'b1, 32'd0, 32'hFFFF_FFFF, 5, 32'd1,         32'd0};
        vecs[11] = '{3'd6, 32'd2,         32'd3,        1'b1, 32'd0, 32'd0,        5,  32'hFFFF_FFFF, 32'hFFFF_FFFA};
        vecs[12] = '{3'd0, 32'h8000_0000, 32'h8000_0000, 1'b0, 32'd0, 32'd0,       5,  32'h4000_0000, 32'd0};
        vecs[13] = '{3'd4, 32'hFFFF_FFFF, 32'd5,        1'b1, 32'd0, 32'd10,       5,  32'd0,         32'd5};
        vecs[14] = '{3'd1, 32'h8000_0000, 32'd2,        1'b0, 32'd0, 32'd0,        5,  32'd1,         32'd0};
        vecs[15] = '{3'd3, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, 32'd0, 32'd0,       10, 32'h8000_0000, 32'd0};

        reset  = 1'b1;
        start  = 1'b0;
        op     = 3'd0;
        mt_hi  = 1'b0;
        mt_lo  = 1'b0;
        rs_val = 32'd0;
        rt_val = 32'd0;
        d_mdft = 1'b0;
        tick;
        tick;
        reset = 1'b0;
        d_mdft = 1'b1;
        #1;
        check("reset_busy", 64'(busy), 64'd0);
        check("reset_hi", 64'(hi), 64'd0);
        check("reset_lo", 64'(lo), 64'd0);
        check("reset_stall_idle", 64'(stall), 64'd0);
        d_mdft = 1'b0;

        for (int i = 0; i < NVEC; i++) begin
            if (vecs[i].pre) begin
                mt_write(1'b1, vecs[i].pre_hi);
                mt_write(1'b0, vecs[i].pre_lo);
            end
            run_op(vecs[i].op, vecs[i].rs, vecs[i].rt, nb);
            check($sformatf("vec%0d_busy_len", i), 64'(nb), 64'(vecs[i].lat));
            check($sformatf("vec%0d_hi", i), 64'(hi), 64'(vecs[i].ex_hi));
            check($sformatf("vec%0d_lo", i), 64'(lo), 64'(vecs[i].ex_lo));
        end

        // Stall held across a div with d_mdft=1, then none with d_mdft=0.
        d_mdft = 1'b1;
        op     = 3'd3;
        rs_val = 32'd100;
        rt_val = 32'd7;
        start  = 1'b1;
        #1;
        check("stall_start_cycle", 64'(stall), 64'd1);
        tick;
        start     = 1'b0;
        nb        = 0;
        stall_cnt = 0;
        while (busy === 1'b1 && nb < 40) begin
            if (stall === 1'b1) stall_cnt++;
            nb++;
            tick;
        end
        check("stall_busy_cycles", 64'(stall_cnt), 64'd10);
        check("stall_after", 64'(stall), 64'd0);

        d_mdft    = 1'b0;
        start     = 1'b1;
        #1;
        stall_cnt = (stall === 1'b1) ? 1 : 0;
        tick;
        start = 1'b0;
        nb    = 0;
        while (busy === 1'b1 && nb < 40) begin
            if (stall === 1'b1) stall_cnt++;
            nb++;
            tick;
        end
        check("nostall_cycles", 64'(stall_cnt), 64'd0);
        check("nostall_busy_len", 64'(nb), 64'd10);

        // Reset in the 4th busy cycle of a div discards the result.
        mt_write(1'b1, 32'h0000_1234);
        op     = 3'd2;
        rs_val = 32'd100;
        rt_val = 32'd7;
        start  = 1'b1;
        tick;
        start = 1'b0;
        check("rst_mid_busy_c1", 64'(busy), 64'd1);
        tick;
        tick;
        tick;
        reset = 1'b1;
        tick;
        reset = 1'b0;
        check("rst_mid_busy", 64'(busy), 64'd0);
        check("rst_mid_hi", 64'(hi), 64'd0);
        check("rst_mid_lo", 64'(lo), 64'd0);
        repeat (12) tick;
        check("rst_mid_no_commit", {hi, lo}, 64'd0);

        // Reset wins over start and mt on the same edge.
        mt_write(1'b0, 32'h0000_00AA);
        reset  = 1'b1;
        start  = 1'b1;
        mt_hi  = 1'b1;
        rs_val = 32'h0000_0077;
        tick;
        reset = 1'b0;
        start = 1'b0;
        mt_hi = 1'b0;
        check("rst_prio_busy", 64'(busy), 64'd0);
        check("rst_prio_hilo", {hi, lo}, 64'd0);

        // Start with a coincident mt: the mt write is dropped.
        mt_write(1'b1, 32'h0000_0055);
        op     = 3'd0;
        rs_val = 32'd2;
        rt_val = 32'd3;
        start  = 1'b1;
        mt_lo  = 1'b1;
        tick;
        start = 1'b0;
        mt_lo = 1'b0;
        nb    = 0;
        while (busy === 1'b1 && nb < 40) begin
            nb++;
            tick;
        end
        check("start_wins_len", 64'(nb), 64'd5);
        check("start_wins_hilo", {hi, lo}, {32'd0, 32'd6});

        // Start and mtlo pulsed mid-divide are protocol violations and must be ignored.
        op     = 3'd3;
        rs_val = 32'd100;
        rt_val = 32'd7;
        start  = 1'b1;
        tick;
        start = 1'b0;
        nb    = 0;
        while (busy === 1'b1 && nb < 40) begin
            nb++;
            if (nb == 3) begin
                $display("note: driving start/mt_lo while busy (protocol violation, expected to be ignored)");
                start  = 1'b1;
                mt_lo  = 1'b1;
                op     = 3'd0;
                rs_val = 32'd3;
                rt_val = 32'd3;
            end else begin
                start = 1'b0;
                mt_lo = 1'b0;
            end
            tick;
        end
        start = 1'b0;
        mt_lo = 1'b0;
        check("busy_ignore_len", 64'(nb), 64'd10);
        check("busy_ignore_hi", 64'(hi), 64'd2);
        check("busy_ignore_lo", 64'(lo), 64'd14);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/mdu_ctrl.md
MDU_CTRL -- requirements
Module: mdu_ctrl

Interface
REQ-001 SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-002 SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-003 SHALL have port start, input, 1 bit: an E-stage multiply/divide-class instruction is valid this cycle.
REQ-004 SHALL have port op, input, 3 bits: the operation; 0 mult, 1 multu, 2 div, 3 divu, 4 madd, 5 maddu, 6 msub, 7 msubu.
REQ-005 SHALL have port mt_hi, input, 1 bit: E-stage mthi valid.
REQ-006 SHALL have port mt_lo, input, 1 bit: E-stage mtlo valid.
REQ-007 SHALL have port rs_val, input, 32 bits: first operand, and the data for mthi/mtlo.
REQ-008 SHALL have port rt_val, input, 32 bits: second operand.
REQ-009 SHALL have port d_mdft, input, 1 bit: the D-stage instruction belongs to the MDFT class (mult/div/madd/msub/mf/mt).
REQ-010 SHALL have port busy, output, 1 bit: an operation is in flight.
REQ-011 SHALL have port stall, output, 1 bit: freeze the D stage.
REQ-012 SHALL have port hi, output, 32 bits: architectural HI register.
REQ-013 SHALL have port lo, output, 32 bits: architectural LO register.

Function
REQ-014 SHALL implement a two-state FSM, IDLE and BUSY, plus a 4-bit down-counter.
REQ-015 In IDLE with start=1, SHALL latch op, rs_val and rt_val and enter BUSY.
- Counter load value: MULT_LAT-1 (=4) for ops 0,1,4,5.
- Counter load value: DIV_LAT-1 (=9) for ops 2,3.
REQ-016 In BUSY, SHALL decrement the counter each cycle.
- When the counter is 0: commit the result to hi/lo on that edge and return to IDLE.
REQ-017 Timing: start sampled at edge T gives busy=1 for cycles T+1..T+L, and new hi/lo visible from T+L+1.
- L = 5 for mult-class ops, 10 for div-class ops.
REQ-018 busy SHALL equal (state==BUSY); it is a registered output.
REQ-019 stall SHALL equal d_mdft & (start | busy); it is combinational.
REQ-020 mult/multu result: {hi,lo} = 64-bit signed or unsigned product of the latched operands.
REQ-021 madd/maddu result: {hi,lo} = {hi,lo} + product.
REQ-022 msub/msubu result: {hi,lo} = {hi,lo} - product.
- Both use the {hi,lo} value at commit time, with 64-bit wrap-around.
REQ-023 div/divu result: lo = quotient, hi = remainder.
- Signed division truncates toward zero; the remainder takes the dividend's sign.
REQ-024 Divide by zero: hi = dividend, lo = 32'hFFFFFFFF, for both div and divu.
REQ-025 Signed overflow 32'h80000000 / -1: lo = 32'h80000000, hi = 0.
REQ-026 In IDLE, mt_hi writes rs_val to hi on the next edge and mt_lo writes rs_val to lo.
- mt_hi, mt_lo and start never coincide; if start is also high, start wins and the mt write is dropped.
REQ-027 start, mt_hi or mt_lo asserted while BUSY SHALL be ignored.
- State, counter and hi/lo stay unaffected.
- The bench flags this as a protocol violation.
REQ-028 hi/lo SHALL change only on commit, on an mt write, or on reset.

Reset
REQ-029 With reset=1 at an edge, the block SHALL go to state IDLE, counter 0, busy 0, hi 0, lo 0.
REQ-030 Reset mid-operation SHALL discard the pending result; no partial commit.
REQ-031 Reset SHALL take priority over start, mt_hi, mt_lo and commit on the same edge.

Structure
REQ-032 Shared package mdu_pkg SHALL hold:
- the op encodings (MD_MULT..MD_MSUBU, 3 bits);
- the state enum (IDLE, BUSY);
- MULT_LAT=5 and DIV_LAT=10.
REQ-033 The arithmetic SHALL live in one combinational sub-module, mdu_alu.
- Inputs: op, latched operands, current {hi,lo}.
- Output: 64-bit result.
- mdu_ctrl holds the FSM, counter and hi/lo registers.

Verification
REQ-034 mult: rs=-3, rt=7, start 1 cycle -> busy high 5 cycles; then hi=FFFFFFFF, lo=FFFFFFEB.
REQ-035 divu: rs=100, rt=7 -> busy high 10 cycles; then lo=14, hi=2.
- div: rs=-7, rt=2 -> lo=FFFFFFFD, hi=FFFFFFFF.
REQ-036 mthi 5, mtlo 10, then madd rs=2, rt=3 -> after 5 busy cycles hi=5, lo=16.
- Follow with msubu rs=16, rt=1 -> lo=0, hi=5.
REQ-037 d_mdft=1 held across a div -> stall=1 on the start cycle and all 10 busy cycles, 0 after.
- d_mdft=0 -> stall=0 throughout.
REQ-038 div started, reset asserted in the 4th busy cycle -> next cycle busy=0, hi=lo=0, no later commit.
REQ-039 divu rs=9, rt=0 -> hi=9, lo=FFFFFFFF.
- div rs=80000000, rt=FFFFFFFF -> lo=80000000, hi=0.
- start pulsed while busy -> no effect on the result or the busy length.
